// File: rtl/ps2_pkg.sv
// PS/2 receiver shared definitions.
// Prefix byte values and frame FSM state encoding.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_NONE  = 8'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

endpackage

// File: rtl/ps2_sync_filter.sv
// PS/2 pin conditioning: 2-FF synchronizers, clock glitch
// filter and a one-cycle strobe on the filtered falling edge.
module ps2_sync_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_sync,
  output logic fall_stb
);

  logic       clk_s1;
  logic       clk_s2;
  logic       dat_s1;
  logic       dat_s2;
  logic       filt;
  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // cnt counts consecutive samples that disagree with filt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt     <= 1'b1;
      cnt      <= 4'd0;
      fall_stb <= 1'b0;
    end else begin
      fall_stb <= 1'b0;
      if (clk_s2 == filt) begin
        cnt <= 4'd0;
      end else if (cnt == 4'(FILTER_LEN - 1)) begin
        filt     <= clk_s2;
        cnt      <= 4'd0;
        fall_stb <= ~clk_s2;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  assign data_sync = dat_s2;

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: frame FSM, timeout, prefix
// decoding and held make code for the display transcoder.
module ps2_receiver #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       break_flag,
  output logic       ext_flag,
  output logic       frame_err
);

  import ps2_pkg::*;

  logic        data_sync;
  logic        fall_stb;
  state_t      state;
  state_t      state_nx;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        par_bit;
  logic [15:0] tmo_cnt;
  logic        pend_break;
  logic        pend_ext;
  logic        frame_ok;
  logic        err;
  logic        timeout;

  ps2_sync_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .data_sync(data_sync),
    .fall_stb (fall_stb)
  );

  assign timeout = (state != IDLE) &&
                   (tmo_cnt == 16'(TIMEOUT_CYCLES));

  always_comb begin
    state_nx = state;
    frame_ok = 1'b0;
    err      = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall_stb) begin
          if (!data_sync) state_nx = DATA;
          else            err      = 1'b1;
        end
      end
      DATA: begin
        if (fall_stb && bit_cnt == 3'd7)
          state_nx = PARITY;
      end
      PARITY: begin
        if (fall_stb) state_nx = STOP;
      end
      STOP: begin
        if (fall_stb) begin
          state_nx = IDLE;
          if (data_sync && (^shreg ^ par_bit))
            frame_ok = 1'b1;
          else
            err = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    // a falling edge in the same cycle beats expiry
    if (timeout && !fall_stb) begin
      state_nx = IDLE;
      err      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= 3'd0;
      shreg   <= 8'd0;
      par_bit <= 1'b0;
      tmo_cnt <= 16'd0;
    end else begin
      if (state == IDLE || fall_stb) tmo_cnt <= 16'd0;
      else                           tmo_cnt <= tmo_cnt + 16'd1;
      if (err) begin
        shreg   <= 8'd0;
        bit_cnt <= 3'd0;
      end else if (fall_stb) begin
        if (state == IDLE) bit_cnt <= 3'd0;
        if (state == DATA) begin
          shreg   <= {data_sync, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (state == PARITY) par_bit <= data_sync;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_code  <= PS2_NONE;
      code_valid <= 1'b0;
      break_flag <= 1'b0;
      ext_flag   <= 1'b0;
      frame_err  <= 1'b0;
      pend_break <= 1'b0;
      pend_ext   <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= err;
      if (err) begin
        pend_break <= 1'b0;
        pend_ext   <= 1'b0;
      end else if (frame_ok) begin
        unique case (1'b1)
          (shreg == PS2_BREAK): pend_break <= 1'b1;
          (shreg == PS2_EXT):   pend_ext   <= 1'b1;
          default: begin
            code_valid <= 1'b1;
            break_flag <= pend_break;
            ext_flag   <= pend_ext;
            pend_break <= 1'b0;
            pend_ext   <= 1'b0;
            if (!pend_break)
              scan_code <= shreg;
            else if (shreg == scan_code)
              scan_code <= PS2_NONE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_receiver.sv
// Self-checking bench for ps2_receiver using an
// expected-output queue filled as frames are driven.
module tb_ps2_receiver;

  localparam int FL   = 4;
  localparam int TO   = 300;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scan_code;
  logic       code_valid;
  logic       break_flag;
  logic       ext_flag;
  logic       frame_err;

  ps2_receiver #(
    .FILTER_LEN    (FL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .scan_code (scan_code),
    .code_valid(code_valid),
    .break_flag(break_flag),
    .ext_flag  (ext_flag),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         err;
    bit         brk;
    bit         ext;
    logic [7:0] scan;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_scan = 8'h00;
  bit         m_brk = 0;
  bit         m_ext = 0;
  longint     cyc = 0;
  longint     fall_cyc = 0;
  longint     err_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && (code_valid || frame_err)) begin
      if (frame_err) err_cyc = cyc;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: valid=%0b err=%0b scan=%h, required no output",
                 code_valid, frame_err, scan_code);
      end else begin
        mon_e = q.pop_front();
        if ({frame_err, code_valid} !== {mon_e.err, !mon_e.err} ||
            (!mon_e.err &&
             {break_flag, ext_flag, scan_code} !==
             {mon_e.brk, mon_e.ext, mon_e.scan})) begin
          errors++;
          $display("FAIL scoreboard: err=%0b valid=%0b brk=%0b ext=%0b scan=%h, required err=%0b brk=%0b ext=%0b scan=%h",
                   frame_err, code_valid, break_flag, ext_flag, scan_code,
                   mon_e.err, mon_e.brk, mon_e.ext, mon_e.scan);
        end
      end
    end
  end

  task automatic half(input logic lvl, input bit glitch);
    repeat (8) @(negedge clk);
    if (glitch) ps2_clk = ~lvl;
    repeat (2) @(negedge clk);
    ps2_clk = lvl;
    repeat (HALF - 10) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b, input bit glitch);
    ps2_data = b;
    half(1'b1, glitch);
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    half(1'b0, glitch);
    ps2_clk = 1'b1;
  endtask

  task automatic send_raw(input logic [7:0] b, input logic par,
                          input logic stop, input int nbits,
                          input bit glitch);
    logic [10:0] bits;
    bits = {stop, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(bits[i], glitch);
  endtask

  task automatic push_err();
    exp_t e;
    e.err = 1; e.brk = 0; e.ext = 0; e.scan = 8'h00;
    q.push_back(e);
    m_brk = 0;
    m_ext = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par,
                           input bit bad_stop, input bit glitch);
    exp_t e;
    if (bad_par || bad_stop) begin
      push_err();
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else begin
      if (!m_brk) m_scan = b;
      else if (b == m_scan) m_scan = 8'h00;
      e.err = 0; e.brk = m_brk; e.ext = m_ext; e.scan = m_scan;
      q.push_back(e);
      m_brk = 0;
      m_ext = 0;
    end
    send_raw(b, (~^b) ^ bad_par, ~bad_stop, 11, glitch);
  endtask

  task automatic check_drain(input string name);
    repeat (20) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d outputs missing, required 0", name, q.size());
    end
    q.delete();
    checks++;
    if (scan_code !== m_scan) begin
      errors++;
      $display("FAIL %s_scan: scan_code=%h, required %h", name, scan_code, m_scan);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({scan_code, code_valid, break_flag, ext_flag, frame_err} !== 12'h0) begin
      errors++;
      $display("FAIL reset: scan=%h v=%0b b=%0b e=%0b err=%0b, required all 0",
               scan_code, code_valid, break_flag, ext_flag, frame_err);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_make();
    send_byte(8'h1C, 0, 0, 0);
    check_drain("make_1c");
  endtask

  task automatic test_break();
    send_byte(8'hF0, 0, 0, 0);
    send_byte(8'h1C, 0, 0, 0);
    check_drain("break_1c");
  endtask

  task automatic test_ext();
    send_byte(8'hE0, 0, 0, 0);
    send_byte(8'h75, 0, 0, 0);
    check_drain("ext_make_75");
    send_byte(8'hE0, 0, 0, 0);
    send_byte(8'hF0, 0, 0, 0);
    send_byte(8'h75, 0, 0, 0);
    check_drain("ext_break_75");
  endtask

  task automatic test_errors();
    send_byte(8'h1C, 0, 0, 0);
    send_byte(8'h16, 1, 0, 0);
    send_byte(8'h16, 0, 1, 0);
    check_drain("bad_frames");
    push_err();
    ps2_bit(1'b1, 0);
    check_drain("start_high");
    send_byte(8'hF0, 0, 0, 0);
    send_byte(8'h1C, 1, 0, 0);
    send_byte(8'h1C, 0, 0, 0);
    check_drain("err_clears_pend");
  endtask

  task automatic test_timeout();
    longint d;
    err_cyc = -1;
    push_err();
    send_raw(8'h35, 1'b0, 1'b1, 6, 0);
    repeat (TO + 10) @(negedge clk);
    check_drain("timeout");
    d = err_cyc - fall_cyc;
    checks++;
    if (err_cyc < 0 || d < TO + FL + 3 || d > TO + FL + 5) begin
      errors++;
      $display("FAIL timeout_latency: %0d cycles, required %0d..%0d",
               d, TO + FL + 3, TO + FL + 5);
    end
    send_byte(8'h45, 0, 0, 0);
    check_drain("after_timeout_45");
  endtask

  task automatic test_glitch();
    send_byte(8'h1E, 0, 0, 1);
    check_drain("glitch_1e");
  endtask

  task automatic test_back_to_back();
    send_byte(8'h1C, 0, 0, 0);
    send_byte(8'h32, 0, 0, 0);
    send_byte(8'hF0, 0, 0, 0);
    send_byte(8'h32, 0, 0, 0);
    send_byte(8'h4B, 0, 0, 0);
    check_drain("back_to_back");
  endtask

  task automatic test_reset_mid();
    send_byte(8'h2B, 0, 0, 0);
    check_drain("pre_reset_2b");
    send_raw(8'h5A, 1'b1, 1'b1, 4, 0);
    ps2_data = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({scan_code, code_valid, break_flag, ext_flag, frame_err} !== 12'h0) begin
      errors++;
      $display("FAIL reset_mid: scan=%h v=%0b b=%0b e=%0b err=%0b, required all 0",
               scan_code, code_valid, break_flag, ext_flag, frame_err);
    end
    m_scan = 8'h00;
    m_brk  = 0;
    m_ext  = 0;
    q.delete();
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_byte(8'h29, 0, 0, 0);
    check_drain("post_reset_29");
  endtask

  initial begin
    test_reset();
    test_make();
    test_break();
    test_ext();
    test_errors();
    test_timeout();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
